// File: rtl/fwpayload_pkg.sv
// Shared types and helpers for the firmware payload memory subsystem.
// Requester IDs, address regions and the arbitration modes live here.
package fwpayload_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        REQ_D  = 2'd0,
        REQ_I  = 2'd1,
        REQ_WB = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        RGN_MEM      = 2'd0,
        RGN_GPO      = 2'd1,
        RGN_UNMAPPED = 2'd2
    } region_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] id;
        region_e    region;
        logic [2:0] gidx;
    } xact_t;

    function automatic region_e decode(
        input logic [31:0] addr,
        input logic [31:0] mem_base,
        input int          mem_bits,
        input logic [31:0] periph_base,
        input int          n_gpo
    );
        logic [31:0] m;
        m = '1;
        m = m << mem_bits;
        if ((addr & m) == (mem_base & m))
            return RGN_MEM;
        if (addr[31:28] == periph_base[31:28] &&
            int'({27'd0, addr[6:2]}) < n_gpo)
            return RGN_GPO;
        return RGN_UNMAPPED;
    endfunction

    // Port that sits k places after 'last' in the D, I, WB ring.
    function automatic logic [1:0] rr_next(
        input logic [1:0] last,
        input int         k
    );
        int s;
        s = (int'(last) + k) % 3;
        return 2'(s);
    endfunction

endpackage

// File: rtl/fwpayload_sp_ram.sv
// Single-port 32-bit RAM, byte write enables, one-cycle registered read.
// Kept behavioural so it can be swapped for an SRAM macro.
module fwpayload_sp_ram #(
    parameter int WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++)
                if (we[b])
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/fwpayload_memsys.sv
// Arbitrates I, D and Wishbone ports onto a shared RAM and GPO bank.
// Each access is one grant cycle followed by one response-pulse cycle.
module fwpayload_memsys
    import fwpayload_pkg::*;
#(
    parameter int          MEM_WORDS   = 4096,
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter logic [31:0] PERIPH_BASE = 32'hC000_0000,
    parameter int          N_GPO       = 2,
    parameter int          ARB_MODE    = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ivalid,
    input  logic [31:0]          iaddr,
    output logic                 iready,
    output logic [31:0]          idata,
    input  logic                 dvalid,
    input  logic [31:0]          daddr,
    input  logic                 dwrite,
    input  logic [31:0]          dwdata,
    input  logic [3:0]           dwstb,
    output logic                 dready,
    output logic [31:0]          drdata,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [32*N_GPO-1:0]  gpo_o,
    output logic                 err_o
);

    localparam int AW = $clog2(MEM_WORDS);

    state_e      state_q, state_d;
    xact_t       cur_q;
    logic [2:0]  req;
    logic [1:0]  last_q, gnt, idx;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_strb;
    logic        sel_write;
    region_e     rgn;
    logic        start, in_resp;
    logic [31:0] ram_rdata, rsp;
    logic [31:0] idata_q, drdata_q, wbdat_q;
    logic [31:0] gpo_q [N_GPO];
    logic        err_q;

    assign req   = {wbs_cyc_i & wbs_stb_i, ivalid, dvalid};
    assign start = (state_q == ST_IDLE) && (|req);

    always_comb begin
        gnt = REQ_D;
        idx = REQ_WB;
        if (ARB_MODE == ARB_RR) begin
            // Walk from farthest to nearest so the nearest requester wins.
            for (int k = 3; k >= 1; k--) begin
                idx = rr_next(last_q, k);
                if (req[idx])
                    gnt = idx;
            end
        end else if (!req[REQ_D]) begin
            if (req[REQ_I])
                gnt = REQ_I;
            else if (req[REQ_WB])
                gnt = REQ_WB;
        end
    end

    always_comb begin
        sel_addr  = wbs_adr_i;
        sel_wdata = wbs_dat_i;
        sel_strb  = wbs_sel_i;
        sel_write = wbs_we_i;
        case (gnt)
            REQ_D: begin
                sel_addr  = daddr;
                sel_wdata = dwdata;
                sel_strb  = dwstb;
                sel_write = dwrite;
            end
            REQ_I: begin
                sel_addr  = iaddr;
                sel_wdata = '0;
                sel_strb  = '0;
                sel_write = 1'b0;
            end
            default: ;
        endcase
    end

    assign rgn = decode(sel_addr, MEM_BASE, AW + 2, PERIPH_BASE, N_GPO);

    fwpayload_sp_ram #(
        .WORDS(MEM_WORDS)
    ) u_ram (
        .clk  (clock),
        .en   (start && rgn == RGN_MEM),
        .we   (sel_write ? sel_strb : 4'b0000),
        .addr (sel_addr[AW+1:2]),
        .wdata(sel_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp = '0;
        case (cur_q.region)
            RGN_MEM: rsp = ram_rdata;
            RGN_GPO:
                for (int k = 0; k < N_GPO; k++)
                    if (cur_q.gidx == 3'(k))
                        rsp = gpo_q[k];
            default: rsp = '0;
        endcase
        in_resp   = (state_q == ST_RESP);
        iready    = in_resp && cur_q.id == REQ_I;
        dready    = in_resp && cur_q.id == REQ_D;
        wbs_ack_o = in_resp && cur_q.id == REQ_WB;
        idata     = iready    ? rsp : idata_q;
        drdata    = dready    ? rsp : drdata_q;
        wbs_dat_o = wbs_ack_o ? rsp : wbdat_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_q    <= '{id: REQ_D, region: RGN_UNMAPPED, gidx: 3'd0};
            last_q   <= REQ_WB;
            err_q    <= 1'b0;
            idata_q  <= '0;
            drdata_q <= '0;
            wbdat_q  <= '0;
            for (int k = 0; k < N_GPO; k++)
                gpo_q[k] <= '0;
        end else begin
            if (start) begin
                cur_q  <= '{id: gnt, region: rgn, gidx: sel_addr[4:2]};
                last_q <= gnt;
                if (rgn == RGN_UNMAPPED)
                    err_q <= 1'b1;
            end
            if (start && rgn == RGN_GPO && sel_write)
                for (int k = 0; k < N_GPO; k++)
                    if (sel_addr[4:2] == 3'(k))
                        for (int b = 0; b < 4; b++)
                            if (sel_strb[b])
                                gpo_q[k][8*b +: 8] <= sel_wdata[8*b +: 8];
            // Read data holds its last pulsed value between responses.
            if (iready)    idata_q  <= rsp;
            if (dready)    drdata_q <= rsp;
            if (wbs_ack_o) wbdat_q  <= rsp;
        end
    end

    for (genvar k = 0; k < N_GPO; k++) begin : g_gpo
        assign gpo_o[32*k +: 32] = gpo_q[k];
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fwpayload_memsys.sv
// Scoreboard bench for fwpayload_memsys: fixed-priority and round-robin
// instances, memory/GPO/unmapped decode and reset behaviour.
module tb_fwpayload_memsys;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    logic        ivalid, iready, dvalid, dwrite, dready;
    logic [31:0] iaddr, idata, daddr, dwdata, drdata;
    logic [3:0]  dwstb, wbs_sel_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o, err_o;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [63:0] gpo_o;

    logic        r_ivalid, r_iready, r_dvalid, r_dwrite, r_dready;
    logic [31:0] r_iaddr, r_idata, r_daddr, r_dwdata, r_drdata;
    logic [3:0]  r_dwstb, r_wbs_sel_i;
    logic        r_wbs_cyc_i, r_wbs_stb_i, r_wbs_we_i, r_wbs_ack_o, r_err_o;
    logic [31:0] r_wbs_adr_i, r_wbs_dat_i, r_wbs_dat_o;
    logic [63:0] r_gpo_o;

    fwpayload_memsys #(.ARB_MODE(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .ivalid(ivalid), .iaddr(iaddr), .iready(iready), .idata(idata),
        .dvalid(dvalid), .daddr(daddr), .dwrite(dwrite), .dwdata(dwdata),
        .dwstb(dwstb), .dready(dready), .drdata(drdata),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .gpo_o(gpo_o), .err_o(err_o)
    );

    fwpayload_memsys #(.ARB_MODE(1)) dut_rr (
        .clock(clock), .reset_n(reset_n),
        .ivalid(r_ivalid), .iaddr(r_iaddr), .iready(r_iready), .idata(r_idata),
        .dvalid(r_dvalid), .daddr(r_daddr), .dwrite(r_dwrite), .dwdata(r_dwdata),
        .dwstb(r_dwstb), .dready(r_dready), .drdata(r_drdata),
        .wbs_cyc_i(r_wbs_cyc_i), .wbs_stb_i(r_wbs_stb_i), .wbs_we_i(r_wbs_we_i),
        .wbs_sel_i(r_wbs_sel_i), .wbs_adr_i(r_wbs_adr_i), .wbs_dat_i(r_wbs_dat_i),
        .wbs_ack_o(r_wbs_ack_o), .wbs_dat_o(r_wbs_dat_o),
        .gpo_o(r_gpo_o), .err_o(r_err_o)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          rd;
    } exp_t;

    exp_t sbq[$];
    int   rrq[$];
    int   compared = 0;
    int   mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    exp_t        m_e;
    logic [31:0] m_p, m_d;

    always @(negedge clock) begin
        if (iready | dready | wbs_ack_o) begin
            check("onehot", 32'($countones({iready, dready, wbs_ack_o})), 1);
            check("sb_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                m_e = sbq.pop_front();
                m_p = dready ? 0 : iready ? 1 : 2;
                m_d = dready ? drdata : iready ? idata : wbs_dat_o;
                check("port", m_p, m_e.port);
                if (m_e.rd)
                    check($sformatf("rdata_p%0d", m_e.port), m_d, m_e.data);
            end
        end
    end

    task automatic xfer(input int port, input logic [31:0] addr,
                        input bit wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp);
        int n;
        bit seen;
        @(negedge clock);
        case (port)
            0: begin
                dvalid = 1; daddr = addr; dwrite = wr;
                dwdata = wdata; dwstb = strb;
            end
            1: begin
                ivalid = 1; iaddr = addr;
            end
            default: begin
                wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = wr;
                wbs_sel_i = strb; wbs_adr_i = addr; wbs_dat_i = wdata;
            end
        endcase
        sbq.push_back('{port, exp, !wr});
        n = 0;
        seen = 0;
        while (!seen && n < 8) begin
            @(negedge clock);
            n++;
            seen = (port == 0) ? dready : (port == 1) ? iready : wbs_ack_o;
        end
        check($sformatf("latency_p%0d", port), 32'(seen ? n : 99), 1);
        dvalid = 0; ivalid = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, td, ti, tw, t, p;
        int w1[3], w2[3];
        {ivalid, dvalid, dwrite, wbs_cyc_i, wbs_stb_i, wbs_we_i} = '0;
        {iaddr, daddr, dwdata, wbs_adr_i, wbs_dat_i} = '0;
        dwstb = '0; wbs_sel_i = '0;
        {r_ivalid, r_dvalid, r_dwrite, r_wbs_cyc_i, r_wbs_stb_i, r_wbs_we_i} = '0;
        r_iaddr = 32'h8000_0000; r_daddr = 32'h8000_0004;
        r_wbs_adr_i = 32'h8000_0008;
        r_dwdata = '0; r_wbs_dat_i = '0; r_dwstb = '0; r_wbs_sel_i = '0;
        for (int q = 0; q < 3; q++) begin w1[q] = 0; w2[q] = 0; end

        repeat (3) @(negedge clock);
        check("rst_pulses", {29'd0, iready, dready, wbs_ack_o}, 0);
        check("rst_idata", idata, 0);
        check("rst_drdata", drdata, 0);
        check("rst_wbdat", wbs_dat_o, 0);
        check("rst_gpo0", gpo_o[31:0], 0);
        check("rst_gpo1", gpo_o[63:32], 0);
        check("rst_err", err_o, 0);
        reset_n = 1;

        xfer(2, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF, 0);
        xfer(1, 32'h8000_0010, 0, 0, 0, 32'hDEAD_BEEF);
        xfer(0, 32'h8000_0020, 1, 32'hFFFF_FFFF, 4'hF, 0);
        xfer(0, 32'h8000_0020, 1, 32'h1122_3344, 4'b0101, 0);
        xfer(0, 32'h8000_0020, 0, 0, 0, 32'hFF22_FF44);
        xfer(2, 32'h8000_0010, 1, 32'hAA00_0000, 4'b1000, 0);
        xfer(0, 32'h8000_0010, 0, 0, 0, 32'hAAAD_BEEF);

        // All three ports request together under fixed priority.
        @(negedge clock);
        c0 = cyc; td = -1; ti = -1; tw = -1;
        dvalid = 1; daddr = 32'h8000_0020; dwrite = 0;
        ivalid = 1; iaddr = 32'h8000_0010;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h8000_0020;
        sbq.push_back('{0, 32'hFF22_FF44, 1});
        sbq.push_back('{1, 32'hAAAD_BEEF, 1});
        sbq.push_back('{2, 32'hFF22_FF44, 1});
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (dready) begin td = cyc - c0; dvalid = 0; end
            if (iready) begin ti = cyc - c0; ivalid = 0; end
            if (wbs_ack_o) begin tw = cyc - c0; wbs_cyc_i = 0; wbs_stb_i = 0; end
        end
        check("arb0_d_cycle", td, 1);
        check("arb0_i_cycle", ti, 3);
        check("arb0_wb_cycle", tw, 5);

        // Sustained requests on the round-robin instance.
        @(negedge clock);
        c0 = cyc;
        r_dvalid = 1; r_ivalid = 1; r_wbs_cyc_i = 1; r_wbs_stb_i = 1;
        repeat (2) begin
            rrq.push_back(0); rrq.push_back(1); rrq.push_back(2);
        end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            p = r_dready ? 0 : r_iready ? 1 : r_wbs_ack_o ? 2 : 3;
            if (p != 3) begin
                t = cyc - c0;
                check("rr_slot_odd", 32'(t % 2), 1);
                check("rr_nonempty", 32'(rrq.size() != 0), 1);
                if (rrq.size() != 0)
                    check("rr_port", p, rrq.pop_front());
                if (t <= 6) w1[p]++; else w2[p]++;
            end
            if (k == 11) begin
                r_dvalid = 0; r_ivalid = 0; r_wbs_cyc_i = 0; r_wbs_stb_i = 0;
            end
        end
        for (int q = 0; q < 3; q++) begin
            check($sformatf("rr_win1_p%0d", q), w1[q], 1);
            check($sformatf("rr_win2_p%0d", q), w2[q], 1);
        end
        check("rr_drain", rrq.size(), 0);

        xfer(0, 32'hC000_0000, 1, 32'h0BAD_F00D, 4'hF, 0);
        xfer(0, 32'hC000_0004, 1, 32'hA5A5_0001, 4'hF, 0);
        check("gpo1_write", gpo_o[63:32], 32'hA5A5_0001);
        check("gpo0_keep", gpo_o[31:0], 32'h0BAD_F00D);
        xfer(0, 32'hC000_0004, 1, 32'h0000_7700, 4'b0010, 0);
        xfer(2, 32'hC000_0004, 0, 0, 4'hF, 32'hA5A5_7701);
        xfer(1, 32'hC000_0000, 0, 0, 0, 32'h0BAD_F00D);
        check("err_after_gpo", err_o, 0);

        xfer(0, 32'h4000_0000, 0, 0, 0, 32'h0);
        check("err_set", err_o, 1);
        xfer(0, 32'hC000_0040, 1, 32'hFFFF_FFFF, 4'hF, 0);
        xfer(0, 32'hC000_0008, 1, 32'hFFFF_FFFF, 4'hF, 0);
        check("gpo0_unmapped", gpo_o[31:0], 32'h0BAD_F00D);
        check("gpo1_unmapped", gpo_o[63:32], 32'hA5A5_7701);
        xfer(0, 32'h8000_3FFC, 1, 32'hCAFE_0001, 4'hF, 0);
        xfer(0, 32'h8000_0000, 1, 32'h0102_0304, 4'hF, 0);
        xfer(0, 32'h8000_4000, 1, 32'hFFFF_FFFF, 4'hF, 0);
        xfer(0, 32'h8000_3FFC, 0, 0, 0, 32'hCAFE_0001);
        xfer(0, 32'h8000_0000, 0, 0, 0, 32'h0102_0304);
        xfer(0, 32'h8000_4000, 0, 0, 0, 32'h0);
        check("err_sticky", err_o, 1);

        // Reset lands in the response cycle of a WB read.
        @(negedge clock);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h8000_0010;
        @(posedge clock);
        #1;
        check("rst_ack_before", wbs_ack_o, 1);
        reset_n = 0;
        #1;
        check("rst_ack_cancel", wbs_ack_o, 0);
        check("rst_wbdat_clear", wbs_dat_o, 0);
        check("rst_gpo_clear0", gpo_o[31:0], 0);
        check("rst_gpo_clear1", gpo_o[63:32], 0);
        check("rst_err_clear", err_o, 0);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;

        xfer(2, 32'h8000_0010, 0, 0, 4'hF, 32'hAAAD_BEEF);
        xfer(0, 32'h8000_0020, 0, 0, 0, 32'hFF22_FF44);
        xfer(1, 32'h8000_3FFC, 0, 0, 0, 32'hCAFE_0001);
        check("err_post_reset", err_o, 0);

        repeat (2) @(negedge clock);
        check("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
